mips_multicycle_control: RTL and testbench
==========================================

// Module: mips_multicycle_control
// PURPOSE
//  Moore FSM controller for the multi-cycle MIPS datapath. Drives the ALU opcode
//  bus (SrcA/SrcB mux selects, ALU_Control), takes back the ALU Zero flag, and
//  sequences PC, IR, memory and register-file enables per instruction.
//  Sits between the instruction register (Opcode/Funct) and the datapath muxes.
// PARAMETERS
//  OP_WIDTH     6   opcode field width
//  FUNCT_WIDTH  6   funct field width
// PORTS
//  CLK          in   1   single clock, all state updates on rising edge
//  RST          in   1   synchronous active-low reset
//  Opcode       in   6   IR[31:26]
//  Funct        in   6   IR[5:0]
//  Zero         in   1   ALU zero flag, same cycle as ALU_Control
//  MemReady     in   1   memory handshake: access completes in cycle where high
//  ALU_Control  out  3   000 AND, 001 OR, 010 ADD, 100 SUB, 101 MUL, 110 SLT
//  ALUSrcA      out  1   0 PC, 1 register A
//  ALUSrcB      out  2   00 reg B, 01 const 4, 10 signext imm, 11 signext imm<<2
//  PCSrc        out  2   00 ALU result, 01 ALUOut register, 10 jump target
//  PCEn         out  1   PC load enable
//  IorD         out  1   0 instr address (PC), 1 data address (ALUOut)
//  MemWrite     out  1   memory write strobe
//  IRWrite      out  1   IR load enable
//  RegDst       out  1   0 rt, 1 rd
//  MemtoReg     out  1   0 ALUOut, 1 data register
//  RegWrite     out  1   register-file write enable
//  Illegal      out  1   one-cycle pulse on undecodable opcode/funct
//  State        out  4   current state, debug/verification only
// BEHAVIOUR
//  State register only sequential element; all outputs decoded from State (+Zero,
//  MemReady, Funct where noted). RST low at an edge -> State=FETCH next cycle.
//  While RST low: PCEn, IRWrite, MemWrite, RegWrite, Illegal forced 0 (reset mid-
//  instruction aborts it; no partial writes). Non-listed outputs default 0.
//  States (encoding) / outputs / next state:
//   FETCH  (0): IorD=0 SrcA=0 SrcB=01 ADD PCSrc=00; IRWrite=PCEn=MemReady;
//               MemReady ? DECODE : FETCH (stall, no PC/IR change)
//   DECODE (1): SrcA=0 SrcB=11 ADD (branch target to ALUOut); by Opcode:
//               100011/101011->MEMADR, 000000->EXEC, 000100->BRANCH,
//               001000->ADDIEX, 000010->JUMP, else Illegal=1 -> FETCH
//   MEMADR (2): SrcA=1 SrcB=10 ADD; lw->MEMRD, sw->MEMWR
//   MEMRD  (3): IorD=1; MemReady ? MEMWB : MEMRD
//   MEMWB  (4): RegDst=0 MemtoReg=1 RegWrite=1 -> FETCH
//   MEMWR  (5): IorD=1 MemWrite=1 (held while stalled); MemReady ? FETCH : MEMWR
//   EXEC   (6): SrcA=1 SrcB=00; Funct 100100 AND, 100101 OR, 100000 ADD,
//               100010 SUB, 011000 MUL (low 32 bits), 101010 SLT -> ALUWB;
//               other Funct: ALU_Control=000, Illegal=1 -> FETCH, no writeback
//   ALUWB  (7): RegDst=1 MemtoReg=0 RegWrite=1 -> FETCH
//   BRANCH (8): SrcA=1 SrcB=00 SUB PCSrc=01; PCEn=Zero -> FETCH
//   ADDIEX (9): SrcA=1 SrcB=10 ADD -> ADDIWB
//   ADDIWB(10): RegDst=0 MemtoReg=0 RegWrite=1 -> FETCH
//   JUMP  (11): PCSrc=10 PCEn=1 -> FETCH
//   12-15 unreachable; if entered -> FETCH, all enables 0.
//  Latency with MemReady tied high (cycles): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
//  Each MemReady-low cycle in FETCH/MEMRD/MEMWR adds exactly one cycle.
//  Opcode/Funct sampled combinationally; IR holds stable after FETCH.
// CONFIGURATION
//  BNE_EN defined: opcode 000101 in DECODE -> BRANCH; in BRANCH PCEn=~Zero for bne,
//   Zero for beq (opcode still held in IR); bne latency 3.
//  BNE_EN undefined: opcode 000101 is illegal (Illegal pulse, DECODE -> FETCH).
// TESTING
//  1 RST low 2 cycles mid-MEMWR -> State=0, MemWrite/RegWrite/PCEn=0 during reset, FETCH after.
//  2 lw (100011), MemReady=1 -> states 0,1,2,3,4,0; RegWrite=1 only in state 4, MemtoReg=1.
//  3 R-type SUB (Funct 100010) -> EXEC shows ALU_Control=100, SrcA=1, SrcB=00; ALUWB RegDst=1.
//  4 beq with Zero=1 then Zero=0 -> PCEn=1/0 in BRANCH, PCSrc=01, ALU_Control=100.
//  5 sw with MemReady low 3 cycles in MEMWR -> MemWrite held 4 cycles, total 7 cycles.
//  6 Opcode 111111 -> Illegal=1 one cycle in DECODE, no enables, back to FETCH; 000101
//    repeated with and without BNE_EN.

Source files
------------

// File: rtl/mips_multicycle_control_if.sv
// Control/status bundle between the multi-cycle MIPS controller and its datapath.
// master = controller side, slave = datapath side.
interface mips_multicycle_control_if #(
  parameter int OP_WIDTH    = 6,
  parameter int FUNCT_WIDTH = 6
);
  logic [OP_WIDTH-1:0]    opcode;
  logic [FUNCT_WIDTH-1:0] funct;
  logic                   zero;
  logic                   mem_ready;
  logic [2:0]             alu_control;
  logic                   alu_src_a;
  logic [1:0]             alu_src_b;
  logic [1:0]             pc_src;
  logic                   pc_en;
  logic                   iord;
  logic                   mem_write;
  logic                   ir_write;
  logic                   reg_dst;
  logic                   mem_to_reg;
  logic                   reg_write;
  logic                   illegal;
  logic [3:0]             state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output alu_control, alu_src_a, alu_src_b, pc_src, pc_en, iord, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, illegal, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  alu_control, alu_src_a, alu_src_b, pc_src, pc_en, iord, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, illegal, state
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Moore FSM controller for the multi-cycle MIPS datapath.
// Optional feature: define BNE_EN to decode bne (opcode 000101) through BRANCH.
module mips_multicycle_control #(
  parameter int OP_WIDTH    = 6,
  parameter int FUNCT_WIDTH = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  mips_multicycle_control_if.master  bus
);

  localparam logic [OP_WIDTH-1:0]    OP_RTYPE = 6'b000000;
  localparam logic [OP_WIDTH-1:0]    OP_LW    = 6'b100011;
  localparam logic [OP_WIDTH-1:0]    OP_SW    = 6'b101011;
  localparam logic [OP_WIDTH-1:0]    OP_BEQ   = 6'b000100;
  localparam logic [OP_WIDTH-1:0]    OP_ADDI  = 6'b001000;
  localparam logic [OP_WIDTH-1:0]    OP_J     = 6'b000010;
`ifdef BNE_EN
  localparam logic [OP_WIDTH-1:0]    OP_BNE   = 6'b000101;
`endif
  localparam logic [FUNCT_WIDTH-1:0] FN_AND   = 6'b100100;
  localparam logic [FUNCT_WIDTH-1:0] FN_OR    = 6'b100101;
  localparam logic [FUNCT_WIDTH-1:0] FN_ADD   = 6'b100000;
  localparam logic [FUNCT_WIDTH-1:0] FN_SUB   = 6'b100010;
  localparam logic [FUNCT_WIDTH-1:0] FN_MUL   = 6'b011000;
  localparam logic [FUNCT_WIDTH-1:0] FN_SLT   = 6'b101010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11
  } state_t;

  state_t     state_r;
  state_t     state_next_s;
  logic [2:0] alu_control_s;
  logic       alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [1:0] pc_src_s;
  logic       pc_en_s;
  logic       iord_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       reg_dst_s;
  logic       mem_to_reg_s;
  logic       reg_write_s;
  logic       illegal_s;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and Moore output decode.
  always_comb begin
    state_next_s  = S_FETCH;
    alu_control_s = 3'b000;
    alu_src_a_s   = 1'b0;
    alu_src_b_s   = 2'b00;
    pc_src_s      = 2'b00;
    pc_en_s       = 1'b0;
    iord_s        = 1'b0;
    mem_write_s   = 1'b0;
    ir_write_s    = 1'b0;
    reg_dst_s     = 1'b0;
    mem_to_reg_s  = 1'b0;
    reg_write_s   = 1'b0;
    illegal_s     = 1'b0;
    case (state_r)
      S_FETCH: begin
        alu_src_b_s   = 2'b01;
        alu_control_s = 3'b010;
        ir_write_s    = bus.mem_ready;
        pc_en_s       = bus.mem_ready;
        state_next_s  = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b_s   = 2'b11;
        alu_control_s = 3'b010;
        case (bus.opcode)
          OP_LW, OP_SW: state_next_s = S_MEMADR;
          OP_RTYPE:     state_next_s = S_EXEC;
          OP_BEQ:       state_next_s = S_BRANCH;
`ifdef BNE_EN
          OP_BNE:       state_next_s = S_BRANCH;
`endif
          OP_ADDI:      state_next_s = S_ADDIEX;
          OP_J:         state_next_s = S_JUMP;
          default: begin
            illegal_s    = 1'b1;
            state_next_s = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_s   = 1'b1;
        alu_src_b_s   = 2'b10;
        alu_control_s = 3'b010;
        state_next_s  = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord_s       = 1'b1;
        state_next_s = bus.mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        mem_to_reg_s = 1'b1;
        reg_write_s  = 1'b1;
        state_next_s = S_FETCH;
      end
      S_MEMWR: begin
        iord_s       = 1'b1;
        mem_write_s  = 1'b1;
        state_next_s = bus.mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a_s  = 1'b1;
        state_next_s = S_ALUWB;
        case (bus.funct)
          FN_AND:  alu_control_s = 3'b000;
          FN_OR:   alu_control_s = 3'b001;
          FN_ADD:  alu_control_s = 3'b010;
          FN_SUB:  alu_control_s = 3'b100;
          FN_MUL:  alu_control_s = 3'b101;
          FN_SLT:  alu_control_s = 3'b110;
          default: begin
            illegal_s    = 1'b1;
            state_next_s = S_FETCH;
          end
        endcase
      end
      S_ALUWB: begin
        reg_dst_s    = 1'b1;
        reg_write_s  = 1'b1;
        state_next_s = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_s   = 1'b1;
        alu_control_s = 3'b100;
        pc_src_s      = 2'b01;
`ifdef BNE_EN
        // The branch opcode is still held in IR, so it selects the polarity here.
        pc_en_s       = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
`else
        pc_en_s       = bus.zero;
`endif
        state_next_s  = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a_s   = 1'b1;
        alu_src_b_s   = 2'b10;
        alu_control_s = 3'b010;
        state_next_s  = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_s  = 1'b1;
        state_next_s = S_FETCH;
      end
      S_JUMP: begin
        pc_src_s     = 2'b10;
        pc_en_s      = 1'b1;
        state_next_s = S_FETCH;
      end
      default: state_next_s = S_FETCH;
    endcase
  end

  // Reset gates every write enable so an aborted instruction leaves no partial update.
  assign bus.pc_en       = pc_en_s & rst;
  assign bus.ir_write    = ir_write_s & rst;
  assign bus.mem_write   = mem_write_s & rst;
  assign bus.reg_write   = reg_write_s & rst;
  assign bus.illegal     = illegal_s & rst;
  assign bus.alu_control = alu_control_s;
  assign bus.alu_src_a   = alu_src_a_s;
  assign bus.alu_src_b   = alu_src_b_s;
  assign bus.pc_src      = pc_src_s;
  assign bus.iord        = iord_s;
  assign bus.reg_dst     = reg_dst_s;
  assign bus.mem_to_reg  = mem_to_reg_s;
  assign bus.state       = state_r;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: per-cycle expected output vectors
// are queued as inputs are driven and popped/compared mid-cycle.
module tb_mips_multicycle_control;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [19:0] sb_q[$];

  mips_multicycle_control_if #(.OP_WIDTH(6), .FUNCT_WIDTH(6)) bus ();
  mips_multicycle_control #(.OP_WIDTH(6), .FUNCT_WIDTH(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  wire [19:0] obs = {bus.state, bus.alu_control, bus.alu_src_a, bus.alu_src_b, bus.pc_src,
                     bus.pc_en, bus.iord, bus.mem_write, bus.ir_write, bus.reg_dst,
                     bus.mem_to_reg, bus.reg_write, bus.illegal};

  task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] pk(logic [3:0] st, logic [2:0] alu, logic sa, logic [1:0] sb,
                                     logic [1:0] ps, logic pcen, logic iord, logic mw,
                                     logic irw, logic rd, logic m2r, logic rw, logic ill);
    return {st, alu, sa, sb, ps, pcen, iord, mw, irw, rd, m2r, rw, ill};
  endfunction

  // One clock: drive handshake inputs, queue the expectation, compare at negedge.
  task automatic cyc(input string tag, input logic [19:0] e, input logic mr, input logic z);
    logic [19:0] exp;
    bus.mem_ready = mr;
    bus.zero      = z;
    sb_q.push_back(e);
    @(negedge clk);
    exp = sb_q.pop_front();
    check(tag, obs, exp);
    @(posedge clk);
    #1;
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic fetch(input logic mr);
    cyc("fetch", pk(4'd0, 3'b010, 1'b0, 2'b01, 2'b00, mr, 1'b0, 1'b0, mr, 1'b0, 1'b0, 1'b0, 1'b0), mr, rb());
  endtask
  task automatic decode(input logic ill);
    cyc("decode", pk(4'd1, 3'b010, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ill), rb(), rb());
  endtask
  task automatic memadr();
    cyc("memadr", pk(4'd2, 3'b010, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), rb(), rb());
  endtask
  task automatic memrd(input logic mr);
    cyc("memrd", pk(4'd3, 3'b000, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), mr, rb());
  endtask
  task automatic memwb();
    cyc("memwb", pk(4'd4, 3'b000, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), rb(), rb());
  endtask
  task automatic memwr(input logic mr);
    cyc("memwr", pk(4'd5, 3'b000, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), mr, rb());
  endtask
  task automatic exec(input logic [2:0] alu, input logic ill);
    cyc("exec", pk(4'd6, alu, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ill), rb(), rb());
  endtask
  task automatic aluwb();
    cyc("aluwb", pk(4'd7, 3'b000, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0), rb(), rb());
  endtask
  task automatic branch(input logic z, input logic pcen);
    cyc("branch", pk(4'd8, 3'b100, 1'b1, 2'b00, 2'b01, pcen, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), rb(), z);
  endtask
  task automatic addiex();
    cyc("addiex", pk(4'd9, 3'b010, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), rb(), rb());
  endtask
  task automatic addiwb();
    cyc("addiwb", pk(4'd10, 3'b000, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), rb(), rb());
  endtask
  task automatic jump();
    cyc("jump", pk(4'd11, 3'b000, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), rb(), rb());
  endtask

  logic [5:0] fn_tab  [6] = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b011000, 6'b101010};
  logic [2:0] alu_tab [6] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110};

  initial begin
    rst           = 1'b0;
    bus.opcode    = 6'b000000;
    bus.funct     = 6'b000000;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    // Reset: FETCH with all enables held off.
    cyc("reset", pk(4'd0, 3'b010, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0);
    rst = 1'b1;

    // lw, no stalls, then with a FETCH stall and a MEMRD stall.
    bus.opcode = 6'b100011;
    fetch(1'b1); decode(1'b0); memadr(); memrd(1'b1); memwb();
    fetch(1'b0); fetch(1'b1); decode(1'b0); memadr(); memrd(1'b0); memrd(1'b1); memwb();

    // sw with three MemReady-low cycles in MEMWR.
    bus.opcode = 6'b101011;
    fetch(1'b1); decode(1'b0); memadr();
    memwr(1'b0); memwr(1'b0); memwr(1'b0); memwr(1'b1);

    // Every R-type funct plus an undecodable one.
    bus.opcode = 6'b000000;
    for (int i = 0; i < 6; i++) begin
      bus.funct = fn_tab[i];
      fetch(1'b1); decode(1'b0); exec(alu_tab[i], 1'b0); aluwb();
    end
    bus.funct = 6'b111111;
    fetch(1'b1); decode(1'b0); exec(3'b000, 1'b1);

    // beq taken / not taken.
    bus.opcode = 6'b000100;
    fetch(1'b1); decode(1'b0); branch(1'b1, 1'b1);
    fetch(1'b1); decode(1'b0); branch(1'b0, 1'b0);

    // addi and j.
    bus.opcode = 6'b001000;
    fetch(1'b1); decode(1'b0); addiex(); addiwb();
    bus.opcode = 6'b000010;
    fetch(1'b1); decode(1'b0); jump();

    // Illegal opcodes.
    bus.opcode = 6'b111111;
    fetch(1'b1); decode(1'b1);
    bus.opcode = 6'b000101;
`ifdef BNE_EN
    fetch(1'b1); decode(1'b0); branch(1'b0, 1'b1);
    fetch(1'b1); decode(1'b0); branch(1'b1, 1'b0);
`else
    fetch(1'b1); decode(1'b1);
    fetch(1'b1); decode(1'b1);
`endif

    // Reset held two cycles in the middle of a stalled store.
    bus.opcode = 6'b101011;
    fetch(1'b1); decode(1'b0); memadr(); memwr(1'b0);
    rst = 1'b0;
    cyc("rst_memwr", pk(4'd5, 3'b000, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0);
    cyc("rst_fetch", pk(4'd0, 3'b010, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0);
    rst = 1'b1;
    bus.opcode = 6'b000010;
    fetch(1'b1); decode(1'b0); jump(); fetch(1'b1);

    check("sb_empty", 20'(sb_q.size()), 20'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
